pattern_bit_serializer: RTL and testbench
=========================================

Name: pattern_bit_serializer

Overview:
Upstream stimulus stage for the serial Moore sequence detector (10101 detector). Loads a parallel test pattern and emits it one bit per clock, MSB-first, on a registered serial line that drives the detector's x input directly. Supports single-shot and continuous loop transmission, abort, and a completed-frame counter for board-level checking.

Parameters:
WIDTH, 16, maximum pattern length in bits
LEN_W, 5, width of len input; must satisfy 2**LEN_W > WIDTH
IDLE_LVL, 1'b0, level driven on x when not transmitting

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request transfer; sampled on rising edge
data_in  input  WIDTH  pattern; bit [len-1] is sent first, bit 0 last
len  input  LEN_W  number of bits to send, captured with start
loop  input  1  sampled at last bit of each frame; 1 = resend immediately
abort  input  1  synchronous stop, highest priority after rst
x  output  1  registered serial bit, feeds detector x
busy  output  1  high while a frame is being shifted
done  output  1  one-cycle pulse after final bit of a non-looped frame
frames  output  8  count of completed frames (looped or not), wraps 255->0

Behaviour:
- Reset (async, rst=1): state=IDLE, x=IDLE_LVL, busy=0, done=0, frames=0, shift reg=0, bit counter=0. Reset mid-frame aborts immediately; no done.
- States: IDLE, SHIFT, DONE.
- IDLE: x=IDLE_LVL, busy=0. On start=1 with len!=0: capture data_in and effective length L=min(len,WIDTH); next cycle state=SHIFT, x=data_in[L-1], busy=1. start with len=0 ignored (stay IDLE, no done, frames unchanged).
- SHIFT: one bit per clock, x takes bits L-1 down to 0 on consecutive cycles; latency start-edge to first bit = 1 clock. Bit counter decrements each clock.
- Last bit (counter=0): frames += 1 on that edge. If loop=1: next cycle x = captured bit [L-1] again, stay SHIFT, no gap, no done. If loop=0: next state DONE.
- DONE: exactly one cycle, done=1, busy=0, x=IDLE_LVL. start in DONE is accepted exactly as in IDLE (DONE->SHIFT, first bit next cycle).
- start while in SHIFT: ignored; data_in/len changes during SHIFT have no effect (pattern is captured).
- abort=1 in any state: next cycle IDLE, x=IDLE_LVL, busy=0, done=0; the frame is not counted. abort and start on the same edge: abort wins.
- len > WIDTH clamps to WIDTH (sends data_in[WIDTH-1:0]).
- frames is 8-bit modular; cleared only by rst.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), default WIDTH/LEN_W constants, IDLE_LVL constant.
- Single module; no sub-module warranted (shift register, down-counter, and frame counter are short inline processes).

Test Plan:
- rst, then start with data_in=16'h0015, len=5, loop=0 -> x = 1,0,1,0,1 on cycles 1-5 after start edge, busy=1 for those 5 cycles, done=1 on cycle 6 with x=0, frames=1; the downstream 10101 detector asserts z after the 5th bit.
- Same pattern with loop=1 for 3 frames, then loop=0 -> 15 contiguous bits 10101 10101 10101 with no gap, single done after the 15th bit, frames=3.
- start with len=0 -> stays IDLE, x=0, busy=0, no done, frames unchanged; start with len=20, data_in=16'h8001 -> 16 bits sent: 1, fourteen 0s, then 1; done on cycle 17.
- start during SHIFT with a different data_in -> ignored, original bits continue; start asserted in the DONE cycle -> new frame's first bit appears on the next cycle.
- abort asserted on the 3rd bit of a 5-bit frame -> next cycle IDLE, x=0, busy=0, no done, frames unchanged; abort together with start in IDLE -> stays IDLE.
- rst asserted asynchronously mid-frame, between clock edges -> x=0, busy=0, done=0, frames=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pattern_bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pattern_bit_serializer_pkg
// Brief   : Shared constants and state encoding for the pattern bit
//           serializer that feeds the 10101 sequence detector.
// Revision: 1.0 - initial release
// ============================================================================
package pattern_bit_serializer_pkg;

  // Default pattern geometry; LEN_W must be wide enough to hold WIDTH itself
  localparam int   c_def_width    = 16;
  localparam int   c_def_len_w    = 5;
  localparam logic c_def_idle_lvl = 1'b0;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : pattern_bit_serializer_pkg
`default_nettype wire

// File: rtl/pattern_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : pattern_bit_serializer
// Brief   : Loads a parallel pattern of up to WIDTH bits and emits it one bit
//           per clock, MSB-first, on a registered serial line. Supports
//           single-shot and continuous-loop frames, abort, and a wrapping
//           completed-frame counter.
// Revision: 1.0 - initial release
// ============================================================================
module pattern_bit_serializer
  import pattern_bit_serializer_pkg::*;
#(
  parameter int   WIDTH    = c_def_width,
  parameter int   LEN_W    = c_def_len_w,
  parameter logic IDLE_LVL = c_def_idle_lvl
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             abort,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frames
);

  localparam logic [LEN_W-1:0] c_width_len = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] c_one_len   = LEN_W'(1);

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;   // bits still to be sent, next one at MSB
  logic [WIDTH-1:0] r_pat;     // captured pattern, left-aligned, for looping
  logic [LEN_W-1:0] r_len;     // effective frame length L
  logic [LEN_W-1:0] r_cnt;     // index of the bit currently on x
  logic             r_x;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_frames;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_pat_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_x_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_frames_nxt;

  // Capture helpers: clamp length and left-align the pattern so that
  // data_in[L-1] sits at the MSB; upper unused bits fall off the top.
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_align;
  logic             w_accept;

  // Clamp requested length to WIDTH and align the incoming pattern
  always_comb begin
    w_len_eff = (len > c_width_len) ? c_width_len : len;
    w_shamt   = c_width_len - w_len_eff;
    w_align   = data_in << w_shamt;
    w_accept  = start && (len != '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; abort overrides every state
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_pat_nxt    = r_pat;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_x_nxt      = IDLE_LVL;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_frames_nxt = r_frames;

    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A start in the DONE cycle is treated exactly like one in IDLE
          w_state_nxt = ST_IDLE;
          if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_pat_nxt   = w_align;
            w_shift_nxt = w_align << 1;
            w_len_nxt   = w_len_eff;
            w_cnt_nxt   = w_len_eff - c_one_len;
            w_x_nxt     = w_align[WIDTH-1];
            w_busy_nxt  = 1'b1;
          end
        end

        ST_SHIFT: begin
          if (r_cnt == '0) begin
            // Last bit is on x now: the frame completes on this edge
            w_frames_nxt = r_frames + 8'd1;
            if (loop) begin
              w_shift_nxt = r_pat << 1;
              w_cnt_nxt   = r_len - c_one_len;
              w_x_nxt     = r_pat[WIDTH-1];
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_shift_nxt = r_shift << 1;
            w_cnt_nxt   = r_cnt - c_one_len;
            w_x_nxt     = r_shift[WIDTH-1];
            w_busy_nxt  = 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_pat    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_x      <= IDLE_LVL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_frames <= 8'd0;
    end else begin
      r_shift  <= w_shift_nxt;
      r_pat    <= w_pat_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_x_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  assign x      = r_x;
  assign busy   = r_busy;
  assign done   = r_done;
  assign frames = r_frames;

endmodule : pattern_bit_serializer
`default_nettype wire

// File: tb/tb_pattern_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pattern_bit_serializer
// Brief   : Self-checking bench for pattern_bit_serializer: directed frames
//           plus randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pattern_bit_serializer;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len;
  logic             loop;
  logic             abort;
  logic             x;
  logic             busy;
  logic             done;
  logic [7:0]       frames;

  int n_tests;
  int n_fail;

  pattern_bit_serializer #(
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .IDLE_LVL(1'b0)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_in(data_in),
    .len    (len),
    .loop   (loop),
    .abort  (abort),
    .x      (x),
    .busy   (busy),
    .done   (done),
    .frames (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the frame is a list of bits; the queue holds the bits
  // still to come after the one currently on the line.
  bit       m_sending;
  bit       m_pat[$];
  bit       m_q[$];
  bit       m_x;
  bit       m_done;
  bit [7:0] m_frames;

  logic [63:0] obs_bits;
  int          n_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sending = 1'b0;
    m_pat.delete();
    m_q.delete();
    m_x      = 1'b0;
    m_done   = 1'b0;
    m_frames = 8'd0;
  endtask

  // Advance the model by one rising edge using the inputs as sampled there
  task automatic model_step();
    int l;
    if (rst) begin
      model_reset();
    end else if (abort) begin
      m_sending = 1'b0;
      m_q.delete();
      m_x    = 1'b0;
      m_done = 1'b0;
    end else if (m_sending) begin
      m_done = 1'b0;
      if (m_q.size() == 0) begin
        m_frames = m_frames + 8'd1;
        if (loop) begin
          m_q = m_pat;
          m_x = m_q.pop_front();
        end else begin
          m_sending = 1'b0;
          m_x       = 1'b0;
          m_done    = 1'b1;
        end
      end else begin
        m_x = m_q.pop_front();
      end
    end else begin
      m_done = 1'b0;
      m_x    = 1'b0;
      if (start && len != 0) begin
        l = (int'(len) > WIDTH) ? WIDTH : int'(len);
        m_pat.delete();
        for (int i = l - 1; i >= 0; i--) m_pat.push_back(data_in[i]);
        m_q       = m_pat;
        m_x       = m_q.pop_front();
        m_sending = 1'b1;
      end
    end
  endtask

  // One clock: step the model at the edge, then compare 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("x", x, m_x);
    check("busy", busy, m_sending);
    check("done", done, m_done);
    check("frames", frames, m_frames);
    obs_bits = {obs_bits[62:0], x};
    if (done) n_done++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l, input logic lp);
    start   = 1'b1;
    data_in = d;
    len     = l;
    loop    = lp;
    obs_bits = '0;
    n_done   = 0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    obs_bits = '0;
    n_done   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    len      = '0;
    loop     = 1'b0;
    abort    = 1'b0;
    model_reset();

    // Reset state
    ticks(2);
    check("reset_x", x, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frames", frames, 8'd0);
    rst = 1'b0;
    tick();

    // Single 5-bit frame 10101
    go(16'h0015, 5'd5, 1'b0);
    ticks(4);
    check("single_bits", obs_bits[4:0], 5'b10101);
    tick();
    check("single_done", done, 1'b1);
    check("single_frames", frames, 8'd1);
    tick();

    // Three looped frames, no gap, single done
    go(16'h0015, 5'd5, 1'b1);
    ticks(10);
    loop = 1'b0;
    ticks(4);
    check("loop_bits", obs_bits[14:0], 15'b101011010110101);
    tick();
    check("loop_done_cnt", n_done, 1);
    check("loop_frames", frames, 8'd4);
    tick();

    // len=0 ignored
    go(16'h0015, 5'd0, 1'b0);
    check("len0_busy", busy, 1'b0);
    ticks(2);
    check("len0_frames", frames, 8'd4);

    // len>WIDTH clamps to 16 bits
    go(16'h8001, 5'd20, 1'b0);
    ticks(15);
    check("clamp_bits", obs_bits[15:0], 16'h8001);
    tick();
    check("clamp_done", done, 1'b1);
    tick();

    // start during SHIFT ignored; start in DONE accepted
    go(16'h0015, 5'd5, 1'b0);
    start = 1'b1; data_in = 16'hFFFF; len = 5'd3;
    ticks(4);
    start = 1'b0;
    check("ign_bits", obs_bits[4:0], 5'b10101);
    tick();
    check("ign_done", done, 1'b1);
    start = 1'b1; data_in = 16'h0003; len = 5'd2;
    tick();
    start = 1'b0;
    check("done_restart_busy", busy, 1'b1);
    check("done_restart_x", x, 1'b1);
    ticks(3);

    // Abort on the 3rd bit, then abort together with start in IDLE
    go(16'h0015, 5'd5, 1'b0);
    ticks(2);
    abort = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_frames", frames, 8'd7);
    start = 1'b1;
    tick();
    check("abort_start_busy", busy, 1'b0);
    start = 1'b0;
    abort = 1'b0;
    ticks(3);
    check("abort_no_done", n_done, 0);

    // Asynchronous reset between edges
    go(16'h00FF, 5'd8, 1'b0);
    ticks(2);
    #2;
    rst = 1'b1;
    #1;
    check("async_x", x, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    check("async_frames", frames, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = WIDTH'($urandom);
      len     = LEN_W'($urandom_range(0, 20));
      loop    = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      tick();
    end
    start = 1'b0; loop = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // Frame counter wrap with 1-bit looped frames
    rst = 1'b1;
    tick();
    rst = 1'b0;
    go(16'h0001, 5'd1, 1'b1);
    ticks(255);
    check("wrap_frames_255", frames, 8'd255);
    tick();
    check("wrap_frames_0", frames, 8'd0);
    loop = 1'b0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pattern_bit_serializer
`default_nettype wire
